// File: rtl/key_pkg.sv
// key_pkg: shared state type and default timing constants
// for the key_filter debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILTER0 = 2'd1,
    DOWN    = 2'd2,
    FILTER1 = 2'd3
  } key_state_t;

  localparam int CNT_20MS = 1_000_000;
  localparam int CNT_2S   = 100_000_000;

endpackage

// File: rtl/key_sync.sv
// key_sync: 3-flop synchronizer on the raw key pin with edge detect.
// Ports: clk, rst_n, key_in -> nedge (falling), pedge (rising).
module key_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic nedge,
  output logic pedge
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= key_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign nedge = s3 & ~s2;
  assign pedge = ~s3 & s2;

endmodule

// File: rtl/key_filter.sv
// key_filter: debounces an active-low key; key_flag pulses per
// confirmed edge, key_state is the level. Ports: clk, rst_n, key_in,
// key_flag, key_state, key_long (only with KEY_FILTER_LONG_PRESS_EN).
module key_filter
  import key_pkg::*;
#(
  parameter int CNT_MAX  = CNT_20MS,
  parameter int LONG_CNT = CNT_2S
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_state
`ifdef KEY_FILTER_LONG_PRESS_EN
  ,
  output logic key_long
`endif
);

  localparam int CW = $clog2(CNT_MAX);

  logic nedge;
  logic pedge;

  key_state_t state;
  key_state_t state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic cnt_done;
  logic flag_nx;
  logic level_nx;

  key_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_in (key_in),
    .nedge  (nedge),
    .pedge  (pedge)
  );

  assign cnt_done = (cnt == CW'(CNT_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      key_flag  <= 1'b0;
      key_state <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      key_flag  <= flag_nx;
      key_state <= level_nx;
    end
  end

  // An opposite edge always wins over a completing window.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (nedge) begin
          state_nx = FILTER0;
          cnt_nx   = '0;
        end
      end
      FILTER0: begin
        if (pedge) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt_done) begin
          state_nx = DOWN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DOWN: begin
        if (pedge) begin
          state_nx = FILTER1;
          cnt_nx   = '0;
        end
      end
      FILTER1: begin
        if (nedge) begin
          state_nx = DOWN;
          cnt_nx   = '0;
        end else if (cnt_done) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    flag_nx  = 1'b0;
    level_nx = key_state;
    if (state == FILTER0 && !pedge && cnt_done) begin
      flag_nx  = 1'b1;
      level_nx = 1'b0;
    end
    if (state == FILTER1 && !nedge && cnt_done) begin
      flag_nx  = 1'b1;
      level_nx = 1'b1;
    end
  end

`ifdef KEY_FILTER_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CNT + 1);

  logic [LW-1:0] lcnt;

  // Holds at LONG_CNT so the pulse fires once per press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt     <= '0;
      key_long <= 1'b0;
    end else if (state != DOWN) begin
      lcnt     <= '0;
      key_long <= 1'b0;
    end else if (lcnt != LW'(LONG_CNT)) begin
      lcnt     <= lcnt + 1'b1;
      key_long <= (lcnt == LW'(LONG_CNT - 1));
    end else begin
      key_long <= 1'b0;
    end
  end
`else
  logic unused_long;
  assign unused_long = ^LONG_CNT;
`endif

endmodule

// File: tb/tb_key_filter.sv
// tb_key_filter: directed checks of key_filter with
// CNT_MAX = 100, LONG_CNT = 1000.
module tb_key_filter;
  import key_pkg::*;

  logic clk;
  logic rst_n;
  logic key_in;
  logic key_flag;
  logic key_state;
`ifdef KEY_FILTER_LONG_PRESS_EN
  logic key_long;
`endif

  int ncmp;
  int nerr;
  int cyc;
  int nflag;
  int flag_cyc;
  int flag_lvl;
  int nlong;
  int long_cyc;
  int t;

  key_filter #(
    .CNT_MAX  (100),
    .LONG_CNT (1000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_flag  (key_flag),
    .key_state (key_state)
`ifdef KEY_FILTER_LONG_PRESS_EN
    ,
    .key_long  (key_long)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (key_flag === 1'b1) begin
        nflag++;
        flag_cyc = cyc;
        flag_lvl = int'(key_state);
      end
`ifdef KEY_FILTER_LONG_PRESS_EN
      if (key_long === 1'b1) begin
        nlong++;
        long_cyc = cyc;
      end
`endif
    end
  endtask

  task automatic bounce(input int n);
    for (int i = 0; i < n; i++) begin
      key_in = ~key_in;
      step(int'($urandom_range(1, 60)));
    end
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;
    cyc = 0;
    nflag = 0;
    nlong = 0;
    flag_cyc = -1;
    long_cyc = -1;
    flag_lvl = -1;
    rst_n = 1'b0;
    key_in = 1'b1;
    step(3);
    check("rst_flag", int'(key_flag), 0);
    check("rst_state", int'(key_state), 1);
    check("rst_fsm", int'(dut.state), int'(IDLE));
`ifdef KEY_FILTER_LONG_PRESS_EN
    check("rst_long", int'(key_long), 0);
`endif
    rst_n = 1'b1;

    // idle hold
    nflag = 0;
    step(500);
    check("idle_nflag", nflag, 0);
    check("idle_state", int'(key_state), 1);

    // press with bounce
    bounce(50);
    check("pbnc_nflag", nflag, 0);
    key_in = 1'b0;
    t = cyc;
    step(200);
    check("press_nflag", nflag, 1);
    check("press_lat", flag_cyc - t, 103);
    check("press_lvl", flag_lvl, 0);
    check("press_state", int'(key_state), 0);

    // release with bounce
    nflag = 0;
    bounce(50);
    check("rbnc_nflag", nflag, 0);
    key_in = 1'b1;
    t = cyc;
    step(200);
    check("rel_nflag", nflag, 1);
    check("rel_lat", flag_cyc - t, 103);
    check("rel_lvl", flag_lvl, 1);
    check("rel_state", int'(key_state), 1);

    // glitch one clock short of a window
    nflag = 0;
    key_in = 1'b0;
    step(99);
    key_in = 1'b1;
    step(200);
    check("gl_nflag", nflag, 0);
    check("gl_state", int'(key_state), 1);
    check("gl_fsm", int'(dut.state), int'(IDLE));

    // reset mid-filter
    nflag = 0;
    key_in = 1'b0;
    step(53);
    check("mid_fsm", int'(dut.state), int'(FILTER0));
    check("mid_cnt", int'(dut.cnt), 50);
    rst_n = 1'b0;
    #1;
    check("mid_rflag", int'(key_flag), 0);
    check("mid_rstate", int'(key_state), 1);
    check("mid_rfsm", int'(dut.state), int'(IDLE));
    step(5);
    check("mid_nflag0", nflag, 0);
    rst_n = 1'b1;
    t = cyc;
    step(150);
    check("mid_nflag", nflag, 1);
    check("mid_lat", flag_cyc - t, 103);
    check("mid_state", int'(key_state), 0);

    // long press
    key_in = 1'b1;
    step(200);
    nflag = 0;
    nlong = 0;
    key_in = 1'b0;
    t = cyc;
    step(1603);
    check("lp_nflag", nflag, 1);
    check("lp_lat", flag_cyc - t, 103);
`ifdef KEY_FILTER_LONG_PRESS_EN
    check("lp_nlong", nlong, 1);
    check("lp_lcyc", long_cyc - flag_cyc, 1000);
`endif
    key_in = 1'b1;
    step(300);
    check("lp_rstate", int'(key_state), 1);
`ifdef KEY_FILTER_LONG_PRESS_EN
    check("lp_nlong2", nlong, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
